aes_word_frontend: RTL and testbench
====================================

# aes_word_frontend

Parametrised word-serial front end for the AES-256 cores. It assembles a 256-bit key and 128-bit blocks from WORD_W-bit input words and launches the encrypt or decrypt core with a selectable mode. It then unpacks the 128-bit result into WORD_W-bit output words. The key is retained across blocks and a completed-block counter is kept. It sits between the bus-side register interface and the AES256 enc/dec datapaths.

## Interface
- WORD_W, 32, input/output word width; legal values 32, 64, 128.
- KEY_WORDS, 256/WORD_W, derived; words per key.
- DATA_WORDS, 128/WORD_W, derived; words per block.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, all state via this reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  WORD_W  key or data word.
- in_addr  in  1  0 = data word, 1 = key word.
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with the last data word only.
- core_start  out  1  one-cycle launch pulse.
- core_mode  out  1  latched mode.
- core_key  out  256  assembled key.
- core_data  out  128  assembled block.
- core_done  in  1  one-cycle completion pulse from core.
- core_result  in  128  core output, valid with core_done.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WORD_W  result word.
- out_last  out  1  marks final word of a block.
- key_loaded  out  1  full key present.
- busy  out  1  state ≠ IDLE.
- blk_cnt  out  16  completed blocks, wraps 0xFFFF→0.

## Operation
- States: IDLE, START, WAIT, DRAIN.
- in_ready = (state==IDLE) & (in_addr | key_loaded). in_ready is combinational on in_addr. Data words are refused until a full key is loaded.
- Packing is MSB-first: the first accepted word lands in bits [top:top-WORD_W+1]. Counters key_cnt and data_cnt advance per accepted word.
- Key word with key_cnt==0: key_loaded clears.
- Key word with key_cnt==KEY_WORDS-1: key_loaded sets and key_cnt wraps to 0.
- Rewriting the key between blocks is allowed. The stored key persists until rewritten or reset.
- Data word with data_cnt==DATA_WORDS-1: in_mode is latched into core_mode, data_cnt returns to 0, and IDLE→START.
- START: core_start=1 for exactly this cycle, then →WAIT.
  - If core_done is asserted during START, capture core_result and go →DRAIN.
- WAIT: on core_done, capture core_result into the output register and go →DRAIN. core_done is ignored in IDLE and DRAIN.
- DRAIN: out_valid=1 and out_data = current word, MSB-first. The word index advances on out_valid & out_ready. out_last=1 on word DATA_WORDS-1.
  - On the last handshake: blk_cnt += 1 and →IDLE.
  - out_data and out_last hold stable while out_ready=0.
- core_key, core_data and core_mode are stable from START until the next accepted word.
- WORD_W=128: KEY_WORDS=2 and DATA_WORDS=1; out_last is asserted on every output word.

## Timing
- Reset values:
  - in_ready=0 and busy=0.
  - core_start=0, core_mode=0, core_key=0, core_data=0.
  - out_valid=0, out_data=0, out_last=0.
  - key_loaded=0 and blk_cnt=0.
  - All counters 0 and state IDLE.
- in_ready is low during the cycle reset is asserted and high for key words on the first cycle after reset deasserts.
- Last data word accepted at cycle T: core_start is high at T+1.
- core_done at cycle D (D ≥ T+1): out_valid is high from D+1. The first word is available at D+1.
- Final output handshake at cycle L: state is IDLE at L+1, and in_ready is high at L+1 if key_loaded.
- Minimum block turnaround: DATA_WORDS input cycles + 1 + core latency + DATA_WORDS output cycles.
- Reset mid-operation (any state) returns to the reset values on the next edge. The key is lost. A core_done that arrives after the reset is ignored.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 → all outputs at the reset values, in_ready=0, no word accepted.
- FIPS-197 encrypt, WORD_W=32:
  - Stimulus: key words 00010203…1c1d1e1f, then data words 00112233, 44556677, 8899aabb, ccddeeff with mode 0.
  - Required: core_key=000102…1f and core_data=00112233445566778899aabbccddeeff. core_start is one cycle after the last word. core_mode=0.
  - Core model returns 8ea2b7ca516745bfeafc49904b496089 after 14 cycles → out words 8ea2b7ca, 516745bf, eafc4990, 4b496089, with out_last on the fourth. blk_cnt=1.
- Data before key: after reset, present in_addr=0 with in_valid=1 → in_ready=0 and nothing accepted. key_loaded stays 0.
- Back-pressure: hold out_ready=0 for 5 cycles on each output word → out_data and out_last stay stable, no word is lost or repeated, and blk_cnt increments once.
- Decrypt with retained key: after the encrypt test, send only data 8ea2b7ca516745bfeafc49904b496089 with mode 1 → core_mode=1 and core_key unchanged. Output is 00112233…eeff and blk_cnt=2.
- WORD_W=128 variant plus reset during WAIT:
  - Send 2 key words, then 1 data word, then assert reset while in WAIT → key_loaded=0 and busy=0. A late core_done produces no out_valid.

Source files
------------

// File: rtl/aes_word_frontend_if.sv
// Word-serial bus bundle between the register interface, the frontend and the AES-256 core.
// The frontend takes the slave view; the bus/core side drives through the master view.
interface aes_word_frontend_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_addr;
    logic              in_mode;
    logic              core_start;
    logic              core_mode;
    logic [255:0]      core_key;
    logic [127:0]      core_data;
    logic              core_done;
    logic [127:0]      core_result;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              key_loaded;
    logic              busy;
    logic [15:0]       blk_cnt;

    modport slave (
        input  in_valid, in_data, in_addr, in_mode, core_done, core_result, out_ready,
        output in_ready, core_start, core_mode, core_key, core_data,
        output out_valid, out_data, out_last, key_loaded, busy, blk_cnt
    );

    modport master (
        output in_valid, in_data, in_addr, in_mode, core_done, core_result, out_ready,
        input  in_ready, core_start, core_mode, core_key, core_data,
        input  out_valid, out_data, out_last, key_loaded, busy, blk_cnt
    );
endinterface

// File: rtl/aes_word_frontend.sv
// Word-serial AES-256 front end: packs key/block words MSB-first, launches the core,
// and streams the 128-bit result back out as WORD_W-bit words.
module aes_word_frontend #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    aes_word_frontend_if.slave bus
);
    localparam int KEY_WORDS  = 256 / WORD_W;
    localparam int DATA_WORDS = 128 / WORD_W;
    localparam logic [3:0] KEY_LAST  = 4'(KEY_WORDS - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [255:0]  key_r;
    logic [127:0]  data_r;
    logic [127:0]  res_r;
    logic          mode_r;
    logic          key_loaded_r;
    logic [3:0]    key_cnt_r;
    logic [3:0]    data_cnt_r;
    logic [3:0]    out_idx_r;
    logic [15:0]   blk_cnt_r;

    logic          in_ready_s;
    logic          core_start_s;
    logic          out_valid_s;
    logic          out_last_s;
    logic          busy_s;
    logic          key_acc_s;
    logic          data_acc_s;
    logic          capture_s;
    logic          out_hs_s;

    assign key_acc_s  = bus.in_valid & in_ready_s & bus.in_addr;
    assign data_acc_s = bus.in_valid & in_ready_s & ~bus.in_addr;
    assign capture_s  = bus.core_done & ((state_r == ST_START) | (state_r == ST_WAIT));
    assign out_hs_s   = out_valid_s & bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (data_acc_s && (data_cnt_r == DATA_LAST)) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bus.core_done) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.core_done) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (out_hs_s && (out_idx_r == DATA_LAST)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; in_ready is forced low while reset is asserted
    always_comb begin
        in_ready_s   = 1'b0;
        core_start_s = 1'b0;
        out_valid_s  = 1'b0;
        out_last_s   = 1'b0;
        busy_s       = 1'b1;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = ~reset & (bus.in_addr | key_loaded_r);
                busy_s     = 1'b0;
            end
            ST_START: core_start_s = 1'b1;
            ST_WAIT:  busy_s       = 1'b1;
            ST_DRAIN: begin
                out_valid_s = 1'b1;
                out_last_s  = (out_idx_r == DATA_LAST);
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Key and block assembly; each accepted word shifts in at the bottom so the first lands on top
    always_ff @(posedge clk) begin
        if (reset) begin
            key_r        <= 256'd0;
            data_r       <= 128'd0;
            mode_r       <= 1'b0;
            key_loaded_r <= 1'b0;
            key_cnt_r    <= 4'd0;
            data_cnt_r   <= 4'd0;
        end else begin
            if (key_acc_s) begin
                key_r <= (key_r << WORD_W) | 256'(bus.in_data);
                if (key_cnt_r == KEY_LAST) begin
                    key_cnt_r    <= 4'd0;
                    key_loaded_r <= 1'b1;
                end else begin
                    key_cnt_r <= key_cnt_r + 4'd1;
                    if (key_cnt_r == 4'd0) begin
                        key_loaded_r <= 1'b0;
                    end
                end
            end
            if (data_acc_s) begin
                data_r <= (data_r << WORD_W) | 128'(bus.in_data);
                if (data_cnt_r == DATA_LAST) begin
                    data_cnt_r <= 4'd0;
                    mode_r     <= bus.in_mode;
                end else begin
                    data_cnt_r <= data_cnt_r + 4'd1;
                end
            end
        end
    end

    // Result capture and drain; the current output word always sits in the top bits of res_r
    always_ff @(posedge clk) begin
        if (reset) begin
            res_r     <= 128'd0;
            out_idx_r <= 4'd0;
            blk_cnt_r <= 16'd0;
        end else begin
            if (capture_s) begin
                res_r     <= bus.core_result;
                out_idx_r <= 4'd0;
            end else if (out_hs_s) begin
                res_r <= res_r << WORD_W;
                if (out_idx_r == DATA_LAST) begin
                    out_idx_r <= 4'd0;
                    blk_cnt_r <= blk_cnt_r + 16'd1;
                end else begin
                    out_idx_r <= out_idx_r + 4'd1;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.core_start = core_start_s;
    assign bus.core_mode  = mode_r;
    assign bus.core_key   = key_r;
    assign bus.core_data  = data_r;
    assign bus.out_valid  = out_valid_s;
    assign bus.out_data   = res_r[127 -: WORD_W];
    assign bus.out_last   = out_last_s;
    assign bus.key_loaded = key_loaded_r;
    assign bus.busy       = busy_s;
    assign bus.blk_cnt    = blk_cnt_r;
endmodule

// File: tb/tb_aes_word_frontend.sv
// Directed bench for aes_word_frontend at WORD_W=32 and WORD_W=128, with the bench acting as the AES core.
module tb_aes_word_frontend;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] JUNK     = 128'hbadbadbadbadbadbadbadbadbadbad00;

    typedef struct {
        logic         load_key;
        logic [255:0] key;
        logic [127:0] data;
        logic         mode;
        logic [127:0] result;
        int           lat;
        int           stall;
        logic [15:0]  exp_blk;
    } blk_vec_t;

    logic clk;
    logic reset32;
    logic reset128;
    int   checks;
    int   failures;
    blk_vec_t vecs[3];

    aes_word_frontend_if #(.WORD_W(32))  b32 ();
    aes_word_frontend_if #(.WORD_W(128)) b128 ();

    aes_word_frontend #(.WORD_W(32))  dut32  (.clk(clk), .reset(reset32),  .bus(b32));
    aes_word_frontend #(.WORD_W(128)) dut128 (.clk(clk), .reset(reset128), .bus(b128));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic addr, input logic [31:0] data, input logic mode);
        int n;
        n = 0;
        b32.in_valid = 1'b1;
        b32.in_addr  = addr;
        b32.in_data  = data;
        b32.in_mode  = mode;
        #1;
        while (!b32.in_ready && n < 20) begin
            cyc();
            n++;
        end
        if (!b32.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send32_timeout: in_ready got 0 expected 1");
        end
        cyc();
        b32.in_valid = 1'b0;
    endtask

    task automatic send128(input logic addr, input logic [127:0] data, input logic mode);
        int n;
        n = 0;
        b128.in_valid = 1'b1;
        b128.in_addr  = addr;
        b128.in_data  = data;
        b128.in_mode  = mode;
        #1;
        while (!b128.in_ready && n < 20) begin
            cyc();
            n++;
        end
        if (!b128.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send128_timeout: in_ready got 0 expected 1");
        end
        cyc();
        b128.in_valid = 1'b0;
    endtask

    initial begin
        blk_vec_t     v;
        logic [127:0] r;
        checks   = 0;
        failures = 0;
        vecs[0] = '{1'b1, FIPS_KEY, FIPS_PT, 1'b0, FIPS_CT, 14, 0, 16'd1};
        vecs[1] = '{1'b0, FIPS_KEY, FIPS_CT, 1'b1, FIPS_PT, 3, 5, 16'd2};
        vecs[2] = '{1'b0, FIPS_KEY, 128'hdeadbeefcafef00d0123456789abcdef, 1'b0,
                    128'h0123456789abcdeffedcba9876543210, 0, 1, 16'd3};

        reset32  = 1'b1;
        reset128 = 1'b1;
        b32.in_valid = 1'b1;  b32.in_addr = 1'b1;  b32.in_data = 32'h11111111;  b32.in_mode = 1'b0;
        b32.core_done = 1'b0; b32.core_result = JUNK; b32.out_ready = 1'b0;
        b128.in_valid = 1'b1; b128.in_addr = 1'b1; b128.in_data = 128'h1; b128.in_mode = 1'b0;
        b128.core_done = 1'b0; b128.core_result = JUNK; b128.out_ready = 1'b0;

        // Two reset cycles with a word presented
        cyc();
        chk("rst_in_ready", b32.in_ready, 1'b0);
        cyc();
        chk("rst_in_ready2", b32.in_ready, 1'b0);
        b32.in_valid  = 1'b0;
        b128.in_valid = 1'b0;
        reset32  = 1'b0;
        reset128 = 1'b0;
        #1;
        chk("rst_busy", b32.busy, 1'b0);
        chk("rst_core_start", b32.core_start, 1'b0);
        chk("rst_core_mode", b32.core_mode, 1'b0);
        chk("rst_core_key", b32.core_key, 256'd0);
        chk("rst_core_data", b32.core_data, 128'd0);
        chk("rst_out_valid", b32.out_valid, 1'b0);
        chk("rst_out_data", b32.out_data, 32'd0);
        chk("rst_out_last", b32.out_last, 1'b0);
        chk("rst_key_loaded", b32.key_loaded, 1'b0);
        chk("rst_blk_cnt", b32.blk_cnt, 16'd0);
        chk("post_rst_ready_key", b32.in_ready, 1'b1);

        // Data before key is refused
        b32.in_addr  = 1'b0;
        b32.in_valid = 1'b1;
        b32.in_data  = 32'hcafecafe;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nokey_in_ready", b32.in_ready, 1'b0);
            cyc();
        end
        b32.in_valid = 1'b0;
        chk("nokey_key_loaded", b32.key_loaded, 1'b0);
        chk("nokey_core_data", b32.core_data, 128'd0);
        chk("nokey_busy", b32.busy, 1'b0);

        // Table-driven blocks on the 32-bit instance
        for (int b = 0; b < 3; b++) begin
            v = vecs[b];
            if (v.load_key) begin
                for (int i = 0; i < 8; i++) send32(1'b1, v.key[255-32*i -: 32], 1'b0);
                chk("key_loaded", b32.key_loaded, 1'b1);
            end
            for (int i = 0; i < 4; i++) send32(1'b0, v.data[127-32*i -: 32], (i == 3) ? v.mode : ~v.mode);
            chk("core_start", b32.core_start, 1'b1);
            chk("core_key", b32.core_key, v.key);
            chk("core_data", b32.core_data, v.data);
            chk("core_mode", b32.core_mode, v.mode);
            chk("start_busy", b32.busy, 1'b1);
            if (v.lat == 0) begin
                b32.core_done   = 1'b1;
                b32.core_result = v.result;
                cyc();
            end else begin
                for (int c = 0; c < v.lat; c++) begin
                    cyc();
                    if (c == 0) begin
                        chk("start_one_cycle", b32.core_start, 1'b0);
                        chk("wait_out_valid", b32.out_valid, 1'b0);
                    end
                end
                b32.core_done   = 1'b1;
                b32.core_result = v.result;
                cyc();
            end
            b32.core_done   = 1'b0;
            b32.core_result = JUNK;
            r = v.result;
            for (int w = 0; w < 4; w++) begin
                for (int s = 0; s < v.stall; s++) begin
                    b32.out_ready = 1'b0;
                    // A stray core_done while draining must not disturb the result
                    b32.core_done = (w == 0 && s == 0) ? 1'b1 : 1'b0;
                    #1;
                    chk("stall_out_valid", b32.out_valid, 1'b1);
                    chk("stall_out_data", b32.out_data, r[127-32*w -: 32]);
                    chk("stall_out_last", b32.out_last, (w == 3) ? 1'b1 : 1'b0);
                    cyc();
                    b32.core_done = 1'b0;
                end
                b32.out_ready = 1'b1;
                #1;
                chk("out_valid", b32.out_valid, 1'b1);
                chk("out_data", b32.out_data, r[127-32*w -: 32]);
                chk("out_last", b32.out_last, (w == 3) ? 1'b1 : 1'b0);
                cyc();
            end
            b32.out_ready = 1'b0;
            b32.in_addr   = 1'b0;
            #1;
            chk("end_busy", b32.busy, 1'b0);
            chk("end_out_valid", b32.out_valid, 1'b0);
            chk("blk_cnt", b32.blk_cnt, v.exp_blk);
            chk("end_in_ready", b32.in_ready, 1'b1);
            chk("end_core_key", b32.core_key, FIPS_KEY);
        end

        // WORD_W=128: one full block, out_last on the single output word
        send128(1'b1, FIPS_KEY[255:128], 1'b0);
        chk("w128_key_half", b128.key_loaded, 1'b0);
        send128(1'b1, FIPS_KEY[127:0], 1'b0);
        chk("w128_key_loaded", b128.key_loaded, 1'b1);
        send128(1'b0, FIPS_PT, 1'b0);
        chk("w128_core_start", b128.core_start, 1'b1);
        chk("w128_core_key", b128.core_key, FIPS_KEY);
        chk("w128_core_data", b128.core_data, FIPS_PT);
        cyc();
        b128.core_done   = 1'b1;
        b128.core_result = FIPS_CT;
        cyc();
        b128.core_done   = 1'b0;
        b128.core_result = JUNK;
        chk("w128_out_valid", b128.out_valid, 1'b1);
        chk("w128_out_data", b128.out_data, FIPS_CT);
        chk("w128_out_last", b128.out_last, 1'b1);
        b128.out_ready = 1'b1;
        cyc();
        b128.out_ready = 1'b0;
        chk("w128_end_busy", b128.busy, 1'b0);
        chk("w128_blk_cnt", b128.blk_cnt, 16'd1);

        // WORD_W=128: reset while waiting on the core, then a late core_done
        send128(1'b0, FIPS_CT, 1'b1);
        chk("w128_core_mode", b128.core_mode, 1'b1);
        cyc();
        chk("w128_wait_busy", b128.busy, 1'b1);
        reset128 = 1'b1;
        cyc();
        reset128 = 1'b0;
        b128.in_addr = 1'b0;
        #1;
        chk("w128_rst_key_loaded", b128.key_loaded, 1'b0);
        chk("w128_rst_busy", b128.busy, 1'b0);
        chk("w128_rst_core_key", b128.core_key, 256'd0);
        chk("w128_rst_blk_cnt", b128.blk_cnt, 16'd0);
        chk("w128_rst_in_ready", b128.in_ready, 1'b0);
        b128.core_done   = 1'b1;
        b128.core_result = FIPS_PT;
        cyc();
        b128.core_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("w128_late_done_out_valid", b128.out_valid, 1'b0);
            cyc();
        end
        chk("w128_late_done_busy", b128.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
